// File: rtl/gpr_access_ctrl.sv
// gpr_access_ctrl: arbitrates a buffered write stream and a three-port read
// stream onto a single register file (32 x 32-bit GPRs, r0 hard-wired to 0).
//
// Ports
//   CLK, RESET                     clock, synchronous active-high reset
//   WR_VALID/WR_READY/WR_ADDR/WR_DATA
//                                  write request; writes to r0 are dropped
//   RD_VALID/RD_READY/RD_{A,B,D}_ADDR
//                                  read request for up to three registers
//   RSP_VALID/RSP_READY/RSP_{A,B,D}/RSP_AEQZ
//                                  read response, held until accepted
//   GPR_WE, C, C_ADDRESS           register-file write port
//   A/B/D_ADDRESS                  register-file read addresses
//   GPR_A/B/D, GPR_AEQZ            register-file read data
//
// Writes are queued in an in-order FIFO and drained while no read is
// pending. A read is only accepted when no buffered write targets one of its
// addresses, so it always observes the architecturally latest value.
module gpr_access_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WR_VALID,
  output logic        WR_READY,
  input  logic [4:0]  WR_ADDR,
  input  logic [31:0] WR_DATA,
  input  logic        RD_VALID,
  output logic        RD_READY,
  input  logic [4:0]  RD_A_ADDR,
  input  logic [4:0]  RD_B_ADDR,
  input  logic [4:0]  RD_D_ADDR,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_A,
  output logic [31:0] RSP_B,
  output logic [31:0] RSP_D,
  output logic        RSP_AEQZ,
  output logic        GPR_WE,
  output logic [31:0] C,
  output logic [4:0]  C_ADDRESS,
  output logic [4:0]  A_ADDRESS,
  output logic [4:0]  B_ADDRESS,
  output logic [4:0]  D_ADDRESS,
  input  logic [31:0] GPR_A,
  input  logic [31:0] GPR_B,
  input  logic [31:0] GPR_D,
  input  logic        GPR_AEQZ
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_RD_WAIT,
    S_RSP
  } state_t;

  state_t state, state_next;

  // Write buffer
  logic [4:0]            fifo_addr [FIFO_DEPTH];
  logic [31:0]           fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_vld;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_next;
  logic                  fifo_full, fifo_empty;

  // Read tracking
  logic [4:0]  rd_a, rd_b, rd_d;
  logic [1:0]  lat_cnt;
  logic        lat_last;
  logic [31:0] rsp_a, rsp_b, rsp_d;
  logic        rsp_aeqz;

  logic hazard, write_forced, rd_ready_int, rd_accept;
  logic wr_accept, push, pop;

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // Per-slot valid bits make the hazard check independent of pointer order.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_vld[PTR_W'(i)] &&
          ((RD_A_ADDR != '0 && fifo_addr[PTR_W'(i)] == RD_A_ADDR) ||
           (RD_B_ADDR != '0 && fifo_addr[PTR_W'(i)] == RD_B_ADDR) ||
           (RD_D_ADDR != '0 && fifo_addr[PTR_W'(i)] == RD_D_ADDR)))
        hazard = 1'b1;
    end
  end

  assign write_forced = fifo_full || (RD_VALID && hazard);
  assign rd_ready_int = (state == S_IDLE) && !hazard && !write_forced && !RESET;
  assign rd_accept    = RD_VALID && rd_ready_int;

  assign wr_accept  = WR_VALID && !fifo_full;
  assign push       = wr_accept && (WR_ADDR != '0);
  assign pop        = (state == S_WRITE) && !fifo_empty;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  assign lat_last = (lat_cnt == 2'(RD_LATENCY - 1));

  // State register
  always_ff @(posedge CLK) begin
    if (RESET)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (rd_accept)
          state_next = S_RD_WAIT;
        else if (!fifo_empty)
          state_next = S_WRITE;
      end
      S_WRITE: begin
        // write_forced is evaluated on the pre-pop buffer; a hazard that the
        // current pop resolves costs at most one extra drain cycle.
        if (count_next == '0 || (RD_VALID && !write_forced))
          state_next = S_IDLE;
      end
      S_RD_WAIT: begin
        if (lat_last)
          state_next = S_RSP;
      end
      S_RSP: begin
        if (RSP_READY)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FIFO storage; slots are qualified by fifo_vld so no reset is needed.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr[wr_ptr] <= WR_ADDR;
      fifo_data[wr_ptr] <= WR_DATA;
    end
  end

  // FIFO control, read latching and response capture
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fifo_vld <= '0;
      rd_a     <= '0;
      rd_b     <= '0;
      rd_d     <= '0;
      lat_cnt  <= '0;
      rsp_a    <= '0;
      rsp_b    <= '0;
      rsp_d    <= '0;
      rsp_aeqz <= 1'b0;
    end else begin
      if (pop) begin
        fifo_vld[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      if (push) begin
        fifo_vld[wr_ptr] <= 1'b1;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      count <= count_next;

      if (rd_accept) begin
        rd_a    <= RD_A_ADDR;
        rd_b    <= RD_B_ADDR;
        rd_d    <= RD_D_ADDR;
        lat_cnt <= '0;
      end else if (state == S_RD_WAIT) begin
        if (lat_last) begin
          // r0 reads as zero whatever the register file returns.
          rsp_a    <= (rd_a == '0) ? '0 : GPR_A;
          rsp_b    <= (rd_b == '0) ? '0 : GPR_B;
          rsp_d    <= (rd_d == '0) ? '0 : GPR_D;
          rsp_aeqz <= (rd_a == '0) ? 1'b1 : GPR_AEQZ;
        end else begin
          lat_cnt <= lat_cnt + 1'b1;
        end
      end
    end
  end

  // Outputs are gated by RESET so an in-flight write or response is dropped
  // in the reset cycle itself rather than one cycle later.
  always_comb begin
    WR_READY  = !fifo_full;
    RD_READY  = rd_ready_int;
    RSP_VALID = (state == S_RSP) && !RESET;
    RSP_A     = rsp_a;
    RSP_B     = rsp_b;
    RSP_D     = rsp_d;
    RSP_AEQZ  = rsp_aeqz;
    GPR_WE    = 1'b0;
    C         = '0;
    C_ADDRESS = '0;
    A_ADDRESS = '0;
    B_ADDRESS = '0;
    D_ADDRESS = '0;
    if (state == S_WRITE && !RESET) begin
      GPR_WE    = 1'b1;
      C         = fifo_data[rd_ptr];
      C_ADDRESS = fifo_addr[rd_ptr];
    end
    if (state == S_RD_WAIT) begin
      A_ADDRESS = rd_a;
      B_ADDRESS = rd_b;
      D_ADDRESS = rd_d;
    end
  end

endmodule

// File: tb/tb_gpr_access_ctrl.sv
// Self-checking bench for gpr_access_ctrl. A register-file model answers the
// DUT's read ports one pipeline stage late (RD_LATENCY = 2), and a reference
// model holds the architectural register values plus a queue of accepted but
// not yet committed writes.
module tb_gpr_access_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT   = 2;

  logic        CLK;
  logic        RESET;
  logic        WR_VALID, WR_READY;
  logic [4:0]  WR_ADDR;
  logic [31:0] WR_DATA;
  logic        RD_VALID, RD_READY;
  logic [4:0]  RD_A_ADDR, RD_B_ADDR, RD_D_ADDR;
  logic        RSP_VALID, RSP_READY;
  logic [31:0] RSP_A, RSP_B, RSP_D;
  logic        RSP_AEQZ;
  logic        GPR_WE;
  logic [31:0] C;
  logic [4:0]  C_ADDRESS, A_ADDRESS, B_ADDRESS, D_ADDRESS;
  logic [31:0] GPR_A, GPR_B, GPR_D;
  logic        GPR_AEQZ;

  gpr_access_ctrl #(
    .FIFO_DEPTH(DEPTH),
    .RD_LATENCY(LAT)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .RD_VALID(RD_VALID), .RD_READY(RD_READY),
    .RD_A_ADDR(RD_A_ADDR), .RD_B_ADDR(RD_B_ADDR), .RD_D_ADDR(RD_D_ADDR),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_A(RSP_A), .RSP_B(RSP_B), .RSP_D(RSP_D), .RSP_AEQZ(RSP_AEQZ),
    .GPR_WE(GPR_WE), .C(C), .C_ADDRESS(C_ADDRESS),
    .A_ADDRESS(A_ADDRESS), .B_ADDRESS(B_ADDRESS), .D_ADDRESS(D_ADDRESS),
    .GPR_A(GPR_A), .GPR_B(GPR_B), .GPR_D(GPR_D), .GPR_AEQZ(GPR_AEQZ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Power-on register contents; r0 is deliberately non-zero in the model so
  // the controller's own r0 forcing is visible, r6 is zero for AEQZ.
  function automatic logic [31:0] init_val(input logic [4:0] i);
    if (i == 5'd0) return 32'hBAD0_BAD0;
    if (i == 5'd6) return 32'h0;
    return {11'h600, i, 16'h1234};
  endfunction

  // Register file: one registered read stage => data valid LAT cycles
  // after the address is presented.
  logic [31:0] gpr [32];
  logic [31:0] gpr_a_q, gpr_b_q, gpr_d_q;
  bit          loaded = 1'b0;

  always @(posedge CLK) begin
    if (!loaded) begin
      for (int i = 0; i < 32; i++) gpr[i] <= init_val(5'(i));
      loaded <= 1'b1;
    end else if (GPR_WE) begin
      gpr[C_ADDRESS] <= C;
    end
    gpr_a_q <= gpr[A_ADDRESS];
    gpr_b_q <= gpr[B_ADDRESS];
    gpr_d_q <= gpr[D_ADDRESS];
  end

  assign GPR_A    = gpr_a_q;
  assign GPR_B    = gpr_b_q;
  assign GPR_D    = gpr_d_q;
  assign GPR_AEQZ = (gpr_a_q == 32'h0);

  // Reference model
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] committed [32];
  logic [31:0] ea, eb, ed;
  logic        eaeqz;
  bit          pending, seen_valid, last_rd_acc;
  int          lat, we_cnt;
  int          n_cmp, n_bad;
  logic [31:0] last_rsp_a, last_rsp_b;
  logic        last_rsp_aeqz;

  function automatic logic [31:0] ref_val(input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0) return 32'h0;
    v = committed[a];
    foreach (wq[i]) if (wq[i].addr == a) v = wq[i].data;
    return v;
  endfunction

  function automatic bit ref_hazard(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    foreach (wq[i])
      if ((a != 0 && wq[i].addr == a) || (b != 0 && wq[i].addr == b) ||
          (d != 0 && wq[i].addr == d)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already driven; check, update model, clock.
  task automatic tick();
    logic [31:0] va, vb, vd;
    #1;
    last_rd_acc = 1'b0;
    if (RESET) begin
      chk("we_in_reset", GPR_WE, 0);
      chk("rsp_valid_in_reset", RSP_VALID, 0);
      wq.delete();
      pending = 1'b0;
    end else begin
      chk("wr_ready", WR_READY, (wq.size() < DEPTH));
      if (wq.size() == DEPTH || (RD_VALID && ref_hazard(RD_A_ADDR, RD_B_ADDR, RD_D_ADDR)))
        chk("rd_ready_blocked", RD_READY, 0);
      if (GPR_WE) begin
        we_cnt++;
        chk("we_expected", (wq.size() > 0), 1);
        if (wq.size() > 0) begin
          wr_t e;
          e = wq.pop_front();
          chk("we_addr", C_ADDRESS, e.addr);
          chk("we_data", C, e.data);
          committed[e.addr] = e.data;
        end
      end
      if (RSP_VALID) begin
        chk("rsp_expected", pending, 1);
        if (!seen_valid) begin
          chk("rsp_latency", lat, LAT + 1);
          seen_valid = 1'b1;
        end
        chk("rsp_a", RSP_A, ea);
        chk("rsp_b", RSP_B, eb);
        chk("rsp_d", RSP_D, ed);
        chk("rsp_aeqz", RSP_AEQZ, eaeqz);
        chk("rd_ready_in_rsp", RD_READY, 0);
        if (RSP_READY) begin
          pending       = 1'b0;
          last_rsp_a    = RSP_A;
          last_rsp_b    = RSP_B;
          last_rsp_aeqz = RSP_AEQZ;
        end
      end
      // A read sees the state before a write accepted in the same cycle.
      if (RD_VALID && RD_READY) begin
        va = ref_val(RD_A_ADDR);
        vb = ref_val(RD_B_ADDR);
        vd = ref_val(RD_D_ADDR);
        ea = va; eb = vb; ed = vd;
        eaeqz = (va == 32'h0);
        pending = 1'b1;
        seen_valid = 1'b0;
        lat = 0;
        last_rd_acc = 1'b1;
      end
      if (WR_VALID && WR_READY && WR_ADDR != 5'd0)
        wq.push_back('{addr: WR_ADDR, data: WR_DATA});
    end
    @(posedge CLK);
    #1;
    if (pending && !seen_valid) lat++;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    int n;
    RSP_READY = 1'b1;
    RD_VALID  = 1'b1;
    RD_A_ADDR = a;
    RD_B_ADDR = b;
    RD_D_ADDR = d;
    n = 0;
    last_rd_acc = 1'b0;
    while (!last_rd_acc && n < 40) begin tick(); n++; end
    RD_VALID = 1'b0;
    chk("rd_accept_bound", last_rd_acc, 1);
    n = 0;
    while (pending && n < 40) begin tick(); n++; end
    chk("rsp_bound", pending, 0);
  endtask

  task automatic drain();
    int n;
    WR_VALID = 1'b0;
    RD_VALID = 1'b0;
    RSP_READY = 1'b1;
    n = 0;
    while ((wq.size() != 0 || pending) && n < 60) begin tick(); n++; end
    chk("drain_bound", (wq.size() == 0 && !pending), 1);
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 32; i++) committed[i] = init_val(5'(i));
    n_cmp = 0; n_bad = 0; we_cnt = 0; lat = 0;
    pending = 1'b0; seen_valid = 1'b0; last_rd_acc = 1'b0;
    ea = '0; eb = '0; ed = '0; eaeqz = 1'b0;
    RESET = 1'b1;
    WR_VALID = 1'b0; WR_ADDR = '0; WR_DATA = '0;
    RD_VALID = 1'b0; RD_A_ADDR = '0; RD_B_ADDR = '0; RD_D_ADDR = '0;
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    repeat (3) tick();

    // Reset state, first cycle after release
    RESET = 1'b0;
    #1;
    chk("rst_wr_ready", WR_READY, 1);
    chk("rst_rd_ready", RD_READY, 1);
    chk("rst_rsp_valid", RSP_VALID, 0);
    chk("rst_gpr_we", GPR_WE, 0);
    chk("rst_c", C, 0);
    chk("rst_addrs", {C_ADDRESS, A_ADDRESS, B_ADDRESS, D_ADDRESS}, 0);
    chk("rst_rsp", {RSP_A ^ RSP_B ^ RSP_D}, 0);
    chk("rst_rsp_aeqz", RSP_AEQZ, 0);

    // Single write then read back
    w0 = we_cnt;
    WR_VALID = 1'b1; WR_ADDR = 5'd5; WR_DATA = 32'hDEAD_BEEF;
    tick();
    WR_VALID = 1'b0;
    repeat (4) tick();
    chk("we_pulse_r5", we_cnt - w0, 1);
    do_read(5'd5, 5'd0, 5'd0);
    chk("rsp_a_r5", last_rsp_a, 32'hDEAD_BEEF);
    chk("rsp_aeqz_r5", last_rsp_aeqz, 0);

    // Write to r0 is dropped; reads of r0 return zero
    w0 = we_cnt;
    WR_VALID = 1'b1; WR_ADDR = 5'd0; WR_DATA = 32'h1234_5678;
    tick();
    WR_VALID = 1'b0;
    repeat (4) tick();
    chk("we_pulse_r0", we_cnt - w0, 0);
    do_read(5'd0, 5'd0, 5'd3);
    chk("rsp_a_r0", last_rsp_a, 32'h0);
    chk("rsp_b_r0", last_rsp_b, 32'h0);
    chk("rsp_aeqz_r0", last_rsp_aeqz, 1);

    // Read alongside a burst of writes; stall the response to fill the FIFO
    RSP_READY = 1'b0;
    RD_VALID = 1'b1; RD_A_ADDR = 5'd9; RD_B_ADDR = 5'd1; RD_D_ADDR = 5'd6;
    for (int i = 0; i < 4; i++) begin
      WR_VALID = 1'b1; WR_ADDR = 5'(i + 1); WR_DATA = $urandom;
      tick();
      if (i == 0) begin
        chk("burst_rd_first", last_rd_acc, 1);
        RD_VALID = 1'b0;
      end
    end
    WR_DATA = 32'hFFFF_0000;
    WR_ADDR = 5'd12;
    #1;
    chk("burst_full", WR_READY, 0);
    repeat (3) tick();
    RSP_READY = 1'b1;
    WR_VALID = 1'b0;
    w0 = 0;
    while (pending && w0 < 20) begin tick(); w0++; end
    chk("burst_rsp_bound", pending, 0);
    chk("burst_rsp_a", last_rsp_a, init_val(5'd9));
    chk("burst_rsp_b_old", last_rsp_b, init_val(5'd1));
    drain();

    // Read blocked behind a buffered write to the same register
    WR_VALID = 1'b1; WR_ADDR = 5'd7; WR_DATA = 32'hA5A5_A5A5;
    tick();
    WR_VALID = 1'b0;
    RD_VALID = 1'b1; RD_A_ADDR = 5'd0; RD_B_ADDR = 5'd7; RD_D_ADDR = 5'd0;
    #1;
    chk("hazard_block", RD_READY, 0);
    do_read(5'd0, 5'd7, 5'd0);
    chk("hazard_rsp_b", last_rsp_b, 32'hA5A5_A5A5);

    // Reset while a read waits and two writes are buffered
    RD_VALID = 1'b1; RD_A_ADDR = 5'd3; RD_B_ADDR = 5'd0; RD_D_ADDR = 5'd0;
    WR_VALID = 1'b1; WR_ADDR = 5'd10; WR_DATA = 32'h0101_0101;
    tick();
    chk("rst_mid_rd_acc", last_rd_acc, 1);
    RD_VALID = 1'b0;
    WR_ADDR = 5'd11; WR_DATA = 32'h0202_0202;
    tick();
    WR_VALID = 1'b0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
    chk("rst_mid_rsp_valid", RSP_VALID, 0);
    chk("rst_mid_gpr_we", GPR_WE, 0);
    chk("rst_mid_wr_ready", WR_READY, 1);
    repeat (6) tick();

    // Randomized traffic with address overlap to provoke hazards
    for (int i = 0; i < 400; i++) begin
      WR_VALID  = ($urandom % 2) == 0;
      WR_ADDR   = 5'($urandom_range(0, 15));
      WR_DATA   = $urandom;
      RD_VALID  = ($urandom % 3) == 0;
      RD_A_ADDR = 5'($urandom_range(0, 15));
      RD_B_ADDR = 5'($urandom_range(0, 15));
      RD_D_ADDR = 5'($urandom_range(0, 15));
      RSP_READY = ($urandom % 4) != 0;
      tick();
    end
    drain();

    for (int i = 1; i < 32; i++)
      chk($sformatf("gpr_final_r%0d", i), gpr[i], committed[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
